// File: rtl/vga_framebuffer_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_framebuffer_arbiter_if
// Purpose : bundles the drawing-engine write handshake and the single-port
//           frame RAM bus used by vga_framebuffer_arbiter.
// Signals :
//   wr_req / wr_addr / wr_data / wr_ready  write handshake (transfer on req && ready)
//   mem_en / mem_we / mem_addr / mem_wdata frame RAM command, driven by the arbiter
//   mem_rdata                              RAM read data, valid 1 clk after a read
// Modports:
//   slave  - the arbiter side
//   master - the drawing engine plus RAM side (stimulus / memory model)
// ---------------------------------------------------------------------------
interface vga_framebuffer_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              wr_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_wdata;
  logic [11:0]       mem_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_framebuffer_arbiter.sv
// ---------------------------------------------------------------------------
// vga_framebuffer_arbiter
// Purpose : shares one single-port frame RAM between the VGA readout and a
//           drawing engine. Every pixel lasts 4 clk (phase 0..3). Phase 0
//           reads the RAM while the display is active; all other slots drain
//           a small write FIFO fed by a req/ready handshake.
// Ports   :
//   clk, rstn      clock (4x pixel rate), asynchronous active-low reset
//   XCoord,YCoord  current VGA counters
//   bus (slave)    write handshake + RAM command/read-data bus
//   pixel_color    registered color to the VGA output stage
//   frame_start    1-clk pulse during phase 0 of pixel (0,0)
//   wr_err         sticky flag, set when an out-of-range write is dropped
// Timing  : the slot schedule is defined at the registered mem_* outputs, so
//           the slot decision for phase p is made while phase_q == p-1. Read
//           data returns during phase 1 and is captured into pixel_color at
//           the end of phase 1.
// ---------------------------------------------------------------------------
module vga_framebuffer_arbiter #(
  parameter int          FB_W       = 160,
  parameter int          FB_H       = 120,
  parameter int          SCALE_SH   = 2,
  parameter int          ADDR_W     = 15,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [9:0]                 XCoord,
  input  logic [9:0]                 YCoord,
  vga_framebuffer_arbiter_if.slave   bus,
  output logic [11:0]                pixel_color,
  output logic                       frame_start,
  output logic                       wr_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 12;

  // State
  logic [1:0]        phase_q,       phase_d;
  logic [CNT_W-1:0]  count_q,       count_d;
  logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
  logic              mem_en_q,      mem_en_d;
  logic              mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [11:0]       mem_wdata_q,   mem_wdata_d;
  logic [11:0]       pixel_color_q, pixel_color_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_err_q,      wr_err_d;
  logic              rd_valid_q,    rd_valid_d;

  // FIFO storage: entries are {addr, data}; no reset needed since the
  // pointers and count define which entries are live.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

  // Combinational helpers
  logic              active;
  logic [9:0]        x_ram;
  logic [9:0]        y_ram;
  logic [ADDR_W-1:0] rd_addr;
  logic              read_slot_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [11:0]       head_data;
  logic              head_in_range;

  always_comb begin
    active     = (XCoord < 10'd640) && (YCoord < 10'd480);
    x_ram      = XCoord >> SCALE_SH;
    y_ram      = YCoord >> SCALE_SH;
    rd_addr    = ADDR_W'(y_ram) * ADDR_W'(FB_W) + ADDR_W'(x_ram);

    // The upcoming phase-0 slot belongs to the readout when the display is
    // active; its registered command becomes visible during phase 0.
    read_slot_next = (phase_q == 2'd3) && active;

    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    push       = bus.wr_req && !fifo_full;
    // Popping uses the registered count, so a word pushed into an empty FIFO
    // is only eligible one clock later.
    pop        = !fifo_empty && !read_slot_next;

    head          = fifo_mem[rd_ptr_q];
    head_addr     = head[ENTRY_W-1:12];
    head_data     = head[11:0];
    head_in_range = 32'(head_addr) < 32'(FB_W * FB_H);
  end

  always_comb begin
    phase_d       = phase_q + 2'd1;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    wr_err_d      = wr_err_q;
    frame_start_d = (phase_q == 2'd3) && (XCoord == 10'd0) && (YCoord == 10'd0);
    rd_valid_d    = mem_en_q && !mem_we_q;
    pixel_color_d = pixel_color_q;

    if (read_slot_next) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end else if (pop) begin
      if (head_in_range) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = head_addr;
        mem_wdata_d = head_data;
      end else begin
        // Out-of-range word is consumed without touching the RAM.
        wr_err_d = 1'b1;
      end
    end

    // rd_valid_q marks that the phase-0 slot just finished was a read, so
    // mem_rdata currently holds this pixel's color.
    if (phase_q == 2'd1) begin
      pixel_color_d = rd_valid_q ? bus.mem_rdata : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q       <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      pixel_color_q <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      pixel_color_q <= pixel_color_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
    end
  end

  assign bus.wr_ready  = !fifo_full;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign pixel_color   = pixel_color_q;
  assign frame_start   = frame_start_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_framebuffer_arbiter
// Drives VGA coordinates and drawing-engine writes, models the frame RAM,
// and checks the arbiter against a write scoreboard and per-phase slot
// expectations derived from the coordinates.
// ---------------------------------------------------------------------------
module tb_vga_framebuffer_arbiter;

  localparam int          ADDR_W  = 15;
  localparam logic [11:0] BG      = 12'h123;
  localparam int          FB_SIZE = 160 * 120;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  x_coord;
  logic [9:0]  y_coord;
  logic [11:0] pixel_color;
  logic        frame_start;
  logic        wr_err;

  vga_framebuffer_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vga_framebuffer_arbiter #(
    .FB_W(160), .FB_H(120), .SCALE_SH(2), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(4), .BG_COLOR(BG)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .XCoord     (x_coord),
    .YCoord     (y_coord),
    .bus        (bus.slave),
    .pixel_color(pixel_color),
    .frame_start(frame_start),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  // Independent phase tracker.
  logic [1:0] tb_phase = 2'd0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_phase <= 2'd0;
    else       tb_phase <= tb_phase + 2'd1;
  end

  // Frame RAM model: registered read, unwritten cells hold a fixed pattern.
  logic [11:0] ram    [0:32767];
  bit          ram_wr [0:32767];

  function automatic logic [11:0] ram_val(input logic [14:0] a);
    logic [31:0] t;
    if (ram_wr[a]) return ram[a];
    if (a == 15'd162) return 12'hABC;
    t = 32'(a) * 32'd7 + 32'h31;
    return t[11:0];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]    <= bus.mem_wdata;
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_val(bus.mem_addr);
      end
    end
  end

  // Bookkeeping
  int          n_err = 0;
  int          n_chk = 0;
  int          fs_seen = 0;
  logic [26:0] sb_q [$];
  logic [14:0] next_a;
  logic [11:0] next_d;
  bit          rec_valid = 1'b0;
  bit          rec_rd = 1'b0;
  bit          rec_fs = 1'b0;
  logic [14:0] rec_addr = '0;
  bit          pix_valid = 1'b0;
  logic [11:0] pix_exp = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called once per falling edge while the DUT outputs are stable.
  task automatic monitor();
    logic [26:0] e;
    logic [31:0] t;
    if (!rstn) begin
      rec_valid = 1'b0;
      pix_valid = 1'b0;
      return;
    end
    if (frame_start) fs_seen++;
    if (bus.mem_en && bus.mem_we) begin
      if (sb_q.size() == 0) begin
        chk("unexp_we", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e[26:12]));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e[11:0]));
        $display("write addr=%0d data=%h phase=%0d", bus.mem_addr, bus.mem_wdata, tb_phase);
      end
    end
    if (bus.mem_en && !bus.mem_we && !(tb_phase == 2'd0 && rec_valid && rec_rd))
      chk("stray_rd", 32'd1, 32'd0);
    case (tb_phase)
      2'd3: begin
        chk("fs_idle", 32'(frame_start), 32'd0);
        rec_rd    = (x_coord < 10'd640) && (y_coord < 10'd480);
        t         = 32'(y_coord >> 2) * 32'd160 + 32'(x_coord >> 2);
        rec_addr  = t[14:0];
        rec_fs    = (x_coord == 10'd0) && (y_coord == 10'd0);
        rec_valid = 1'b1;
      end
      2'd0: begin
        if (rec_valid) begin
          chk("fs", 32'(frame_start), 32'(rec_fs));
          if (rec_rd) begin
            chk("rd_en", 32'(bus.mem_en), 32'd1);
            chk("rd_we", 32'(bus.mem_we), 32'd0);
            chk("rd_addr", 32'(bus.mem_addr), 32'(rec_addr));
            pix_exp = ram_val(rec_addr);
          end else begin
            pix_exp = BG;
          end
          pix_valid = 1'b1;
        end
      end
      2'd2: begin
        chk("fs_idle", 32'(frame_start), 32'd0);
        if (pix_valid) chk("pixel", 32'(pixel_color), 32'(pix_exp));
      end
      default: chk("fs_idle", 32'(frame_start), 32'd0);
    endcase
  endtask

  task automatic step(input bit req, input logic [14:0] a, input logic [11:0] d, output bit acc);
    monitor();
    bus.wr_req  = req;
    bus.wr_addr = a;
    bus.wr_data = d;
    acc = req && bus.wr_ready && rstn;
    if (acc && (32'(a) < FB_SIZE)) sb_q.push_back({a, d});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, '0, '0, a);
  endtask

  task automatic push_step();
    bit acc;
    step(1'b1, next_a, next_d, acc);
    if (acc) begin
      next_a = next_a + 15'd1;
      next_d = next_d + 12'd1;
    end
  endtask

  // Coordinates change only at phase 1 so they are stable when sampled.
  task automatic set_xy(input logic [9:0] x, input logic [9:0] y, input bit keep_push);
    int guard = 0;
    while (tb_phase != 2'd1 && guard < 8) begin
      if (keep_push) push_step();
      else idle(1);
      guard++;
    end
    x_coord = x;
    y_coord = y;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit full_seen;
    int guard;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    x_coord     = 10'd8;
    y_coord     = 10'd4;
    next_a      = 15'd100;
    next_d      = 12'h100;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_en", 32'(bus.mem_en), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_pix", 32'(pixel_color), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    rstn = 1'b1;
    chk("rel_en", 32'(bus.mem_en), 32'd0);

    // Active pixel X=8,Y=4 reads address 162 and shows 12'hABC
    idle(12);
    guard = 0;
    while (tb_phase != 2'd2 && guard < 8) begin idle(1); guard++; end
    chk("pix_abc", 32'(pixel_color), 32'h0ABC);

    // Back-to-back writes while active until the FIFO fills
    full_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      push_step();
      if (!bus.wr_ready) begin
        full_seen = 1'b1;
        break;
      end
    end
    chk("fifo_full", 32'(full_seen), 32'd1);

    // Blanking: writes occupy every slot, including phase 0
    set_xy(10'd700, 10'd4, 1'b1);
    guard = 0;
    while (tb_phase != 2'd0 && guard < 8) begin push_step(); guard++; end
    for (int i = 0; i < 4; i++) begin
      chk("blank_we", 32'(bus.mem_we), 32'd1);
      push_step();
    end
    idle(12);
    chk("drained", 32'(sb_q.size()), 32'd0);
    chk("drain_ready", 32'(bus.wr_ready), 32'd1);
    guard = 0;
    while (tb_phase != 2'd2 && guard < 8) begin idle(1); guard++; end
    chk("pix_bg", 32'(pixel_color), 32'(BG));

    // Out-of-range write: accepted, dropped, sticky error
    chk("err_before", 32'(wr_err), 32'd0);
    step(1'b1, 15'd19200, 12'hEEE, acc);
    chk("oor_acc", 32'(acc), 32'd1);
    idle(6);
    chk("err_set", 32'(wr_err), 32'd1);
    step(1'b1, 15'd5, 12'h555, acc);
    idle(8);
    chk("err_sticky", 32'(wr_err), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a drain while active
    set_xy(10'd8, 10'd4, 1'b0);
    for (int i = 0; i < 12; i++) push_step();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
    chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("mid_rst_err", 32'(wr_err), 32'd0);
    sb_q.delete();
    rec_valid   = 1'b0;
    pix_valid   = 1'b0;
    bus.wr_req  = 1'b0;
    @(negedge clk);
    idle(2);
    rstn = 1'b1;
    idle(8);
    chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);

    // One pixel at (0,0) gives exactly one frame_start pulse
    fs_seen = 0;
    set_xy(10'd0, 10'd0, 1'b0);
    idle(4);
    set_xy(10'd4, 10'd0, 1'b0);
    idle(8);
    chk("fs_count", 32'(fs_seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
